// File: rtl/mips_mon_pkg.sv
// mips_mon_pkg: shared opcodes, monitor state encoding and trace entry layout for retire_monitor.
package mips_mon_pkg;

    localparam logic [5:0] OPC_SPECIAL   = 6'h00;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_BREAK   = 6'h0D;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} mon_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_entry_t;

    function automatic logic is_special(input logic [31:0] inst, input logic [5:0] funct);
        return (inst[31:26] == OPC_SPECIAL) && (inst[5:0] == funct);
    endfunction

endpackage

// File: rtl/mon_fifo.sv
// mon_fifo: first-word-fall-through trace FIFO; head holds the last popped entry while empty.
module mon_fifo
    import mips_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic                       push_i,
    input  trace_entry_t               entry_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output trace_entry_t               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    trace_entry_t  hold_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          empty, full, pop, wr_en;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign pop     = pop_i & ~empty;
    assign wr_en   = push_i & (~full | pop);
    assign drop_o  = push_i & full & ~pop;
    assign valid_o = ~empty;
    assign data_o  = empty ? hold_q : mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_q] <= entry_i;
    end

    // Pointers, occupancy and the held head value; reset empties the FIFO at once.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                hold_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/retire_monitor.sv
// retire_monitor: counts retires, detects syscall, enforces a cycle budget and traces writebacks.
// Optional RETIRE_MONITOR_BREAK_EN: break also terminates and drives the break_hit output.
module retire_monitor
    import mips_mon_pkg::*;
#(
    parameter int MAX_CYCLES = 500,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ret_valid,
    input  logic [31:0]      ret_pc,
    input  logic [31:0]      ret_inst,
    input  logic             ret_wen,
    input  logic [4:0]       ret_waddr,
    input  logic [31:0]      ret_wdata,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [68:0]      trc_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic             halted,
    output logic             timeout,
    output logic             overflow,
`ifdef RETIRE_MONITOR_BREAK_EN
    output logic             break_hit,
`endif
    output logic             done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;
    logic             halted_q, halted_d, timeout_q, timeout_d, overflow_q;
    logic             term, push, pop, drop;
    logic [AW:0]      fifo_cnt;
    trace_entry_t     entry, head;

`ifdef RETIRE_MONITOR_BREAK_EN
    logic brk, brk_q, brk_d;
    assign brk  = is_special(ret_inst, FUNCT_BREAK);
    assign term = is_special(ret_inst, FUNCT_SYSCALL) | brk;
    assign break_hit = brk_q;
`else
    assign term = is_special(ret_inst, FUNCT_SYSCALL);
`endif

    assign entry       = '{pc: ret_pc, waddr: ret_waddr, wdata: ret_wdata};
    assign push        = ret_valid & ret_wen & (|ret_waddr) & (state_q == RUN);
    assign pop         = trc_valid & trc_ready;
    assign trc_data    = head;
    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign done        = (state_q == DONE) | (state_q == TIMEOUT);

    mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i  (clock),
        .reset_ni (reset),
        .push_i   (push),
        .entry_i  (entry),
        .pop_i    (trc_ready),
        .valid_o  (trc_valid),
        .data_o   (head),
        .count_o  (fifo_cnt),
        .drop_o   (drop)
    );

    // Next state: count in RUN, syscall beats the budget, DRAIN waits for the FIFO to empty.
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        inst_d    = inst_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
`ifdef RETIRE_MONITOR_BREAK_EN
        brk_d     = brk_q;
`endif
        case (state_q)
            RUN: begin
                cycle_d = cycle_q + 1'b1;
                inst_d  = ret_valid ? inst_q + 1'b1 : inst_q;
                if (ret_valid & term) begin
                    halted_d = 1'b1;
                    state_d  = DRAIN;
`ifdef RETIRE_MONITOR_BREAK_EN
                    brk_d    = brk;
`endif
                end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = TIMEOUT;
                end
            end
            DRAIN: state_d = (fifo_cnt == '0 || (fifo_cnt == (AW+1)'(1) && pop)) ? DONE : DRAIN;
            default: ;
        endcase
    end

    // State, counters and sticky flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cycle_q    <= '0;
            inst_q     <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef RETIRE_MONITOR_BREAK_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_q | drop;
`ifdef RETIRE_MONITOR_BREAK_EN
            brk_q      <= brk_d;
`endif
        end
    end

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed and randomized checks of retire_monitor against a queue-based reference model.
module tb_retire_monitor;

    localparam int MAXC  = 500;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ret_valid = 1'b0, ret_wen = 1'b0, trc_ready = 1'b0;
    logic [31:0] ret_pc = '0, ret_inst = '0, ret_wdata = '0;
    logic [4:0]  ret_waddr = '0;
    logic        trc_valid, halted, timeout, overflow, done;
    logic [68:0] trc_data;
    logic [31:0] cycle_count, inst_count;
`ifdef RETIRE_MONITOR_BREAK_EN
    logic        break_hit;
`endif

    retire_monitor #(.MAX_CYCLES(MAXC), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .ret_valid   (ret_valid),
        .ret_pc      (ret_pc),
        .ret_inst    (ret_inst),
        .ret_wen     (ret_wen),
        .ret_waddr   (ret_waddr),
        .ret_wdata   (ret_wdata),
        .trc_valid   (trc_valid),
        .trc_ready   (trc_ready),
        .trc_data    (trc_data),
        .cycle_count (cycle_count),
        .inst_count  (inst_count),
        .halted      (halted),
        .timeout     (timeout),
        .overflow    (overflow),
`ifdef RETIRE_MONITOR_BREAK_EN
        .break_hit   (break_hit),
`endif
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef enum {M_RUN, M_DRAIN, M_DONE, M_TIMEOUT} m_state_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [68:0] mq[$];
    logic [68:0] seen[$];
    logic [68:0] m_last;
    logic [31:0] m_cyc, m_inst;
    bit          m_halt, m_to, m_ovf, m_brk;
    m_state_t    m_st;

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_term(input logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
`ifdef RETIRE_MONITOR_BREAK_EN
        return op == 6'h00 && (fn == 6'h0C || fn == 6'h0D);
`else
        return op == 6'h00 && fn == 6'h0C;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_cyc  = '0;
        m_inst = '0;
        m_halt = 0;
        m_to   = 0;
        m_ovf  = 0;
        m_brk  = 0;
        m_st   = M_RUN;
    endtask

    task automatic compare_all();
        check("trc_valid", 69'(trc_valid), 69'(mq.size() != 0));
        check("trc_data", trc_data, mq.size() != 0 ? mq[0] : m_last);
        check("cycle_count", 69'(cycle_count), 69'(m_cyc));
        check("inst_count", 69'(inst_count), 69'(m_inst));
        check("halted", 69'(halted), 69'(m_halt));
        check("timeout", 69'(timeout), 69'(m_to));
        check("overflow", 69'(overflow), 69'(m_ovf));
        check("done", 69'(done), 69'(m_st == M_DONE || m_st == M_TIMEOUT));
`ifdef RETIRE_MONITOR_BREAK_EN
        check("break_hit", 69'(break_hit), 69'(m_brk));
`endif
    endtask

    // One clock edge: the model applies the same inputs, then every output is compared.
    task automatic tick();
        bit          pop_m, push_m, term_m;
        logic [68:0] e;
        if (trc_valid && trc_ready) seen.push_back(trc_data);
        pop_m  = (mq.size() != 0) && trc_ready;
        push_m = ret_valid && ret_wen && (ret_waddr != 0);
        term_m = ret_valid && is_term(ret_inst);
        e      = {ret_pc, ret_waddr, ret_wdata};
        @(posedge clock);
        #1;
        if (pop_m) m_last = mq.pop_front();
        if (m_st == M_RUN) begin
            if (push_m) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1;
            end
            if (ret_valid) m_inst++;
            if (term_m) begin
                m_halt = 1;
                m_brk  = ret_inst[5:0] == 6'h0D;
                m_st   = M_DRAIN;
            end else if (m_cyc == MAXC - 1) begin
                m_to = 1;
                m_st = M_TIMEOUT;
            end
            m_cyc++;
        end else if (m_st == M_DRAIN && mq.size() == 0) begin
            m_st = M_DONE;
        end
        compare_all();
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] inst, input logic wen,
                          input logic [4:0] wa, input logic [31:0] wd);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_inst  = inst;
        ret_wen   = wen;
        ret_waddr = wa;
        ret_wdata = wd;
    endtask

    task automatic idle();
        ret_valid = 1'b0;
        ret_wen   = 1'b0;
        ret_inst  = '0;
        ret_waddr = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        idle();
        trc_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen.delete();
    endtask

    task automatic drain_until_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_within_budget", 69'(done), 69'(1));
    endtask

    initial begin
        model_reset();

        // Two traced writes, a write to $0, then syscall with a ready consumer.
        do_reset();
        trc_ready = 1'b1;
        retire(32'h0040_0000, 32'h2008_0001, 1'b1, 5'd8, 32'd1); tick();
        retire(32'h0040_0004, 32'h2009_0002, 1'b1, 5'd9, 32'd2); tick();
        retire(32'h0040_0008, 32'h2000_0005, 1'b1, 5'd0, 32'd5); tick();
        retire(32'h0040_000C, 32'h0000_000C, 1'b0, 5'd0, 32'd0); tick();
        idle();
        drain_until_done(20);
        check("s1_inst_count", 69'(inst_count), 69'(4));
        check("s1_halted", 69'(halted), 69'(1));
        check("s1_trace_len", 69'(seen.size()), 69'(2));
        if (seen.size() == 2) begin
            check("s1_trace0", seen[0], {32'h0040_0000, 5'd8, 32'd1});
            check("s1_trace1", seen[1], {32'h0040_0004, 5'd9, 32'd2});
        end

        // No syscall ever: budget expires on edge 500.
        do_reset();
        retire(32'h0040_0000, 32'h0000_0000, 1'b0, 5'd0, 32'd0);
        repeat (MAXC - 1) tick();
        check("to_before", 69'(timeout), 69'(0));
        tick();
        check("to_timeout", 69'(timeout), 69'(1));
        check("to_cycles", 69'(cycle_count), 69'(500));
        check("to_halted", 69'(halted), 69'(0));
        check("to_done", 69'(done), 69'(1));
        repeat (3) tick();
        check("to_frozen", 69'(cycle_count), 69'(500));

        // Ten traced writes into a stalled FIFO of eight.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            retire(32'h0040_0000 + 32'(4 * i), 32'h2000_0000 | 32'(i), 1'b1, 5'(i), 32'(i * 7));
            tick();
        end
        retire(32'h0040_0100, 32'h0000_000C, 1'b0, 5'd0, 32'd0); tick();
        idle();
        check("ov_overflow", 69'(overflow), 69'(1));
        repeat (3) tick();
        check("ov_not_done", 69'(done), 69'(0));
        trc_ready = 1'b1;
        seen.delete();
        drain_until_done(20);
        check("ov_drained", 69'(seen.size()), 69'(8));
        if (seen.size() == 8) begin
            check("ov_first", seen[0], {32'h0040_0004, 5'd1, 32'd7});
            check("ov_last", seen[7], {32'h0040_0020, 5'd8, 32'd56});
        end

        // Syscall on the very last budget cycle wins over the timeout.
        do_reset();
        repeat (MAXC - 1) tick();
        check("edge_cycles", 69'(cycle_count), 69'(499));
        retire(32'h0040_0000, 32'h0000_000C, 1'b0, 5'd0, 32'd0); tick();
        idle();
        check("edge_halted", 69'(halted), 69'(1));
        check("edge_timeout", 69'(timeout), 69'(0));
        tick();
        check("edge_done", 69'(done), 69'(1));

        // Asynchronous reset in DRAIN with three queued entries.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            retire(32'h0040_0000 + 32'(4 * i), 32'h2000_0000, 1'b1, 5'(i + 3), 32'(i));
            tick();
        end
        retire(32'h0040_0010, 32'h0000_000C, 1'b0, 5'd0, 32'd0); tick();
        idle();
        check("mr_queued", 69'(trc_valid), 69'(1));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mr_valid", 69'(trc_valid), 69'(0));
        check("mr_cycles", 69'(cycle_count), 69'(0));
        check("mr_insts", 69'(inst_count), 69'(0));
        compare_all();
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("mr_running", 69'(cycle_count), 69'(1));

        // break instruction.
        do_reset();
        retire(32'h0040_0000, 32'h0000_000D, 1'b0, 5'd0, 32'd0); tick();
`ifdef RETIRE_MONITOR_BREAK_EN
        check("brk_halted", 69'(halted), 69'(1));
        check("brk_hit", 69'(break_hit), 69'(1));
`else
        check("brk_counted", 69'(inst_count), 69'(1));
        check("brk_not_halted", 69'(halted), 69'(0));
        retire(32'h0040_0004, 32'h0000_0000, 1'b0, 5'd0, 32'd0); tick();
        check("brk_continues", 69'(inst_count), 69'(2));
`endif
        idle();

        // Randomized traffic against the model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                ret_valid = $urandom_range(0, 3) != 0;
                ret_pc    = $urandom;
                ret_inst  = ($urandom_range(0, 50) == 0) ? 32'h0000_000C :
                            ($urandom_range(0, 30) == 0) ? 32'h0000_000D : $urandom;
                ret_wen   = $urandom_range(0, 1) == 1;
                ret_waddr = 5'($urandom_range(0, 31));
                ret_wdata = $urandom;
                trc_ready = $urandom_range(0, 2) != 0;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
